// File: rtl/ex_mem_dump_reader_if.sv
// ============================================================================
// Module   : ex_mem_dump_reader_if
// Brief    : Memory read port and dump stream bundle for ex_mem_dump_reader.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ex_mem_dump_reader_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 32
);
   logic              mem_rd_en;
   logic              mem_rd_sel;
   logic [ADDR_W-1:0] mem_rd_address;
   logic [DATA_W-1:0] mem_rd_data1;
   logic [DATA_W-1:0] mem_rd_data2;
   logic              dump_valid;
   logic              dump_ready;
   logic [DATA_W-1:0] dump_data;
   logic [ADDR_W-1:0] dump_address;
   logic              dump_last;

   modport master (
      output mem_rd_en, mem_rd_sel, mem_rd_address,
      input  mem_rd_data1, mem_rd_data2,
      output dump_valid, dump_data, dump_address, dump_last,
      input  dump_ready
   );

   modport slave (
      input  mem_rd_en, mem_rd_sel, mem_rd_address,
      output mem_rd_data1, mem_rd_data2,
      input  dump_valid, dump_data, dump_address, dump_last,
      output dump_ready
   );
endinterface

`default_nettype wire

// File: rtl/ex_mem_dump_reader.sv
// ============================================================================
// Module   : ex_mem_dump_reader
// Brief    : Reads N 64-bit entries from data/instruction memory while halted
//            and streams each as two 32-bit beats to the debug host.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ex_mem_dump_reader #(
   parameter int ADDR_W    = 9,
   parameter int DATA_W    = 32,
   parameter int ADDR_STEP = 8,
   parameter int CNT_W     = 6
) (
   input  wire logic              clk,
   input  wire logic              rst_n,
   input  wire logic              i_enable_halt,
   input  wire logic              i_start,
   input  wire logic              i_mem_sel,
   input  wire logic [ADDR_W-1:0] i_start_address,
   input  wire logic [CNT_W-1:0]  i_num_entries,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_aborted,
   ex_mem_dump_reader_if.master   bus
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_REQ     = 3'd1,
      S_CAP     = 3'd2,
      S_SEND_LO = 3'd3,
      S_SEND_HI = 3'd4,
      S_FIN     = 3'd5
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_sel;
   logic [DATA_W-1:0] r_buf_lo;
   logic [DATA_W-1:0] r_buf_hi;
   logic              r_zero_done;
   logic              r_aborted;
   logic              w_halt_lost;
   logic              w_load;
   logic              w_zero_start;
   logic              w_beat_hi;

   assign w_halt_lost  = (r_state != S_IDLE) && !i_enable_halt;
   assign w_load       = (r_state == S_IDLE) && i_start && i_enable_halt && (i_num_entries != '0);
   assign w_zero_start = (r_state == S_IDLE) && i_start && i_enable_halt && (i_num_entries == '0);
   assign w_beat_hi    = (r_state == S_SEND_HI) && bus.dump_ready && !w_halt_lost;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Losing halt overrides every transition, including a pending handshake.
   always_comb begin
      w_next = r_state;
      if (w_halt_lost) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:    if (w_load) w_next = S_REQ;
            S_REQ:     w_next = S_CAP;
            S_CAP:     w_next = S_SEND_LO;
            S_SEND_LO: if (bus.dump_ready) w_next = S_SEND_HI;
            S_SEND_HI: if (bus.dump_ready) w_next = (r_cnt == CNT_W'(1)) ? S_FIN : S_REQ;
            S_FIN:     w_next = S_IDLE;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   always_comb begin
      bus.mem_rd_en      = 1'b0;
      bus.mem_rd_address = '0;
      bus.dump_valid     = 1'b0;
      bus.dump_data      = '0;
      bus.dump_address   = '0;
      bus.dump_last      = 1'b0;
      case (r_state)
         S_REQ: begin
            bus.mem_rd_en      = 1'b1;
            bus.mem_rd_address = r_addr;
         end
         S_SEND_LO: begin
            bus.dump_valid   = 1'b1;
            bus.dump_data    = r_buf_lo;
            bus.dump_address = r_addr;
         end
         S_SEND_HI: begin
            bus.dump_valid   = 1'b1;
            bus.dump_data    = r_buf_hi;
            bus.dump_address = r_addr;
            bus.dump_last    = (r_cnt == CNT_W'(1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_addr      <= '0;
         r_cnt       <= '0;
         r_sel       <= 1'b0;
         r_buf_lo    <= '0;
         r_buf_hi    <= '0;
         r_zero_done <= 1'b0;
         r_aborted   <= 1'b0;
      end else begin
         r_zero_done <= w_zero_start;
         r_aborted   <= w_halt_lost;
         if (w_load) begin
            // Entries are 8-byte aligned; low address bits are discarded.
            r_addr <= {i_start_address[ADDR_W-1:3], 3'b000};
            r_cnt  <= i_num_entries;
            r_sel  <= i_mem_sel;
         end
         if (r_state == S_CAP) begin
            r_buf_lo <= bus.mem_rd_data1;
            r_buf_hi <= bus.mem_rd_data2;
         end
         if (w_beat_hi) begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_addr <= r_addr + ADDR_W'(ADDR_STEP);
         end
      end
   end

   assign bus.mem_rd_sel = r_sel;
   assign o_busy         = (r_state != S_IDLE);
   assign o_done         = (r_state == S_FIN) || r_zero_done;
   assign o_aborted      = r_aborted;

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_dump_reader.sv
// ============================================================================
// Module   : tb_ex_mem_dump_reader
// Brief    : Self-checking bench for ex_mem_dump_reader against a beat-queue model.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ex_mem_dump_reader;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 32;
   localparam int CNT_W  = 6;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              enable_halt = 1'b0;
   logic              start = 1'b0;
   logic              mem_sel = 1'b0;
   logic [ADDR_W-1:0] start_address = '0;
   logic [CNT_W-1:0]  num_entries = '0;
   logic              busy, done, aborted;
   int                n_pass = 0;
   int                n_chk  = 0;
   logic [31:0]       dm1 [64];
   logic [31:0]       dm2 [64];
   logic [31:0]       im1 [64];
   logic [31:0]       im2 [64];

   ex_mem_dump_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();

   ex_mem_dump_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_STEP(8), .CNT_W(CNT_W)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_enable_halt   (enable_halt),
      .i_start         (start),
      .i_mem_sel       (mem_sel),
      .i_start_address (start_address),
      .i_num_entries   (num_entries),
      .o_busy          (busy),
      .o_done          (done),
      .o_aborted       (aborted),
      .bus             (bus)
   );

   always #5 clk = ~clk;

   // Memories with one cycle of read latency.
   always @(posedge clk) begin
      if (bus.mem_rd_en) begin
         bus.mem_rd_data1 <= bus.mem_rd_sel ? im1[bus.mem_rd_address[8:3]] : dm1[bus.mem_rd_address[8:3]];
         bus.mem_rd_data2 <= bus.mem_rd_sel ? im2[bus.mem_rd_address[8:3]] : dm2[bus.mem_rd_address[8:3]];
      end
   end

   task automatic check_value(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   task automatic check_all_zero(input string tag);
      check_value({tag, "_valid"}, bus.dump_valid, 0);
      check_value({tag, "_data"}, bus.dump_data, 0);
      check_value({tag, "_daddr"}, bus.dump_address, 0);
      check_value({tag, "_last"}, bus.dump_last, 0);
      check_value({tag, "_rden"}, bus.mem_rd_en, 0);
      check_value({tag, "_rdsel"}, bus.mem_rd_sel, 0);
      check_value({tag, "_rdaddr"}, bus.mem_rd_address, 0);
      check_value({tag, "_busy"}, busy, 0);
      check_value({tag, "_done"}, done, 0);
      check_value({tag, "_abort"}, aborted, 0);
   endtask

   // rmode: 0 ready always 1, 1 random ready, 2 ready pattern 1-0-0-1
   task automatic run_dump(input logic [ADDR_W-1:0] base, input int n, input logic sel,
                           input int rmode, input int abort_at);
      logic [31:0]       exp_d[$];
      logic [ADDR_W-1:0] exp_a[$];
      logic              exp_l[$];
      logic [ADDR_W-1:0] exp_rd[$];
      logic [ADDR_W-1:0] a;
      logic [31:0]       pd;
      logic [ADDR_W-1:0] pa;
      logic              pl;
      int beats, dones, aborts, cyc, pat;
      bit stalled, fin, dropped, ready;
      localparam bit [3:0] PAT = 4'b1001;

      for (int i = 0; i < n; i++) begin
         a = ADDR_W'((base & 9'h1F8) + 8 * i);
         exp_rd.push_back(a);
         exp_d.push_back(sel ? im1[a[8:3]] : dm1[a[8:3]]);
         exp_a.push_back(a);
         exp_l.push_back(1'b0);
         exp_d.push_back(sel ? im2[a[8:3]] : dm2[a[8:3]]);
         exp_a.push_back(a);
         exp_l.push_back(i == n - 1);
      end

      @(negedge clk);
      enable_halt   = 1'b1;
      start         = 1'b1;
      mem_sel       = sel;
      start_address = base;
      num_entries   = CNT_W'(n);
      bus.dump_ready = 1'b1;
      @(negedge clk);
      start         = 1'b0;
      mem_sel       = ~sel;
      start_address = ADDR_W'($urandom);
      num_entries   = CNT_W'($urandom);

      beats = 0; dones = 0; aborts = 0; cyc = 1; pat = 0;
      stalled = 0; fin = 0; dropped = 0;
      while (!fin && cyc < 400) begin
         if (cyc == 1) check_value("busy_run", busy, 1);
         if (done) begin
            dones++;
            if (rmode == 0 && abort_at < 0) check_value("latency", cyc, 4 * n + 1);
            fin = 1;
         end
         if (aborted) begin
            aborts++;
            check_value("abort_valid", bus.dump_valid, 0);
            check_value("abort_busy", busy, 0);
            fin = 1;
         end
         if (bus.mem_rd_en) begin
            if (exp_rd.size() == 0) check_value("rd_extra", 1, 0);
            else begin
               check_value("rd_addr", bus.mem_rd_address, exp_rd.pop_front());
               check_value("rd_sel", bus.mem_rd_sel, sel);
            end
         end
         if (stalled) begin
            check_value("stall_valid", bus.dump_valid, 1);
            check_value("stall_data", bus.dump_data, pd);
            check_value("stall_addr", bus.dump_address, pa);
            check_value("stall_last", bus.dump_last, pl);
         end
         if (!fin) begin
            if (abort_at >= 0 && !dropped && beats == abort_at) begin
               enable_halt = 1'b0;
               dropped = 1;
            end
            start = (rmode == 1 && cyc == 3);
            if (start) num_entries = CNT_W'($urandom_range(1, 20));
            case (rmode)
               0:       ready = 1'b1;
               1:       ready = ($urandom_range(0, 2) != 0);
               default: ready = PAT[3 - (pat % 4)];
            endcase
            if (bus.dump_valid) pat++;
            bus.dump_ready = ready;
            if (bus.dump_valid && ready && enable_halt) begin
               if (exp_d.size() == 0) check_value("beat_extra", 1, 0);
               else begin
                  check_value("beat_data", bus.dump_data, exp_d.pop_front());
                  check_value("beat_addr", bus.dump_address, exp_a.pop_front());
                  check_value("beat_last", bus.dump_last, exp_l.pop_front());
               end
               beats++;
            end
            stalled = bus.dump_valid && !ready && enable_halt;
            pd = bus.dump_data;
            pa = bus.dump_address;
            pl = bus.dump_last;
            @(negedge clk);
            cyc++;
         end
      end
      start = 1'b0;
      check_value("finished", fin, 1);
      check_value("beats", beats, (abort_at >= 0) ? abort_at : 2 * n);
      check_value("dones", dones, (abort_at >= 0) ? 0 : 1);
      check_value("aborts", aborts, (abort_at >= 0) ? 1 : 0);
      if (abort_at < 0) check_value("rd_left", exp_rd.size(), 0);
      @(negedge clk);
      check_value("post_done", done, 0);
      check_value("post_abort", aborted, 0);
      check_value("post_busy", busy, 0);
      enable_halt    = 1'b1;
      bus.dump_ready = 1'b1;
   endtask

   initial begin
      int rd_seen, busy_seen, done_seen, n, at;
      bit ok;

      for (int i = 0; i < 64; i++) begin
         dm1[i] = $urandom; dm2[i] = $urandom; im1[i] = $urandom; im2[i] = $urandom;
      end
      dm1[0] = 32'hFFFFAA80; dm2[0] = 32'h00000000;
      dm1[1] = 32'h80000000; dm2[1] = 32'h40000000;
      dm1[2] = 32'h00400000; dm2[2] = 32'h00400000;
      bus.dump_ready = 1'b1;

      #2;
      check_all_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_dump(9'h000, 1, 1'b0, 0, -1);
      run_dump(9'h008, 2, 1'b0, 0, -1);
      run_dump(9'h008, 2, 1'b0, 2, -1);
      run_dump(9'h1F8, 2, 1'b0, 0, -1);
      run_dump(9'h020, 3, 1'b0, 0, 1);
      run_dump(9'h020, 3, 1'b1, 0, -1);

      // Zero-length request: done without ever going busy.
      @(negedge clk);
      start = 1'b1; num_entries = '0; enable_halt = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_value("zero_done", done, 1);
      check_value("zero_busy", busy, 0);
      @(negedge clk);
      check_value("zero_done_clr", done, 0);

      // Asynchronous reset while the high beat is presented.
      start = 1'b1; start_address = 9'h040; num_entries = 6'd2; mem_sel = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ok = 0;
      for (int i = 0; i < 10 && !ok; i++) begin
         if (bus.dump_valid) ok = 1;
         else @(negedge clk);
      end
      check_value("rst_reach_lo", ok, 1);
      @(negedge clk);
      check_value("rst_in_hi", bus.dump_valid, 1);
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;

      // Start without halt must be ignored.
      enable_halt = 1'b0; start = 1'b1; num_entries = 6'd3;
      @(negedge clk);
      start = 1'b0;
      rd_seen = 0; busy_seen = 0; done_seen = 0;
      for (int i = 0; i < 8; i++) begin
         rd_seen   += int'(bus.mem_rd_en);
         busy_seen += int'(busy);
         done_seen += int'(done);
         @(negedge clk);
      end
      check_value("nohalt_rd", rd_seen, 0);
      check_value("nohalt_busy", busy_seen, 0);
      check_value("nohalt_done", done_seen, 0);
      enable_halt = 1'b1;

      for (int t = 0; t < 24; t++) begin
         n  = $urandom_range(1, 6);
         at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2 * n - 1) : -1;
         run_dump(ADDR_W'($urandom), n, 1'($urandom), $urandom_range(0, 2), at);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

`default_nettype wire
